order_issue_queue: RTL and testbench
====================================

// Module: order_issue_queue
// PURPOSE
//   In-order issue queue for ordered pipes (LSU/CSR/branch); successor of the single-dispatch ordered RS.
//   - Accepts up to DISPATCH_WIDTH micro-ops per cycle.
//   - Tracks two source-operand ready bits per entry, woken by WB_WIDTH writeback ports.
//   - Issues strictly oldest-first, one per cycle, with a valid/ready handshake.
//   - Sits between rename/dispatch and one in-order functional unit.
// PARAMETERS
//   RS_SIZE         8   entry count, >=2; need not be a power of two
//   DISPATCH_WIDTH  2   dispatch lanes per cycle, 1..RS_SIZE
//   WB_WIDTH        4   writeback wake-up ports
//   PREG_W          6   physical register tag width
//   PAYLOAD_W       64  opaque payload width (decoded option code + base fields)
// PORTS
//   clk               in   1                  clock
//   rst               in   1                  synchronous reset, active high
//   flush_i           in   1                  synchronous pipeline flush
//   wr_valid_i        in   DW                 per-lane dispatch valid
//   wr_psrc0_i        in   DW*PREG_W          lane source-0 tag
//   wr_psrc0_valid_i  in   DW                 source 0 used
//   wr_psrc0_ready_i  in   DW                 source 0 already ready at dispatch
//   wr_psrc1_i        in   DW*PREG_W          lane source-1 tag
//   wr_psrc1_valid_i  in   DW                 source 1 used
//   wr_psrc1_ready_i  in   DW                 source 1 already ready at dispatch
//   wr_payload_i      in   DW*PAYLOAD_W       lane payload
//   wr_ready_o        out  1                  free entries >= DISPATCH_WIDTH
//   wb_i              in   WB_WIDTH           writeback valid
//   wb_pdest_i        in   WB_WIDTH*PREG_W    writeback dest tag
//   issue_valid_o     out  1                  head entry valid and operands ready
//   issue_ready_i     in   1                  FU accepts head
//   issue_payload_o   out  PAYLOAD_W          head payload
//   count_o           out  clog2(RS_SIZE)+1   occupied entries (registered)
// BEHAVIOUR
//   State
//   - Circular buffer with head and tail pointers and a count.
//   - Pointers wrap from RS_SIZE-1 to 0 explicitly, including the non-power-of-2 case.
//   Dispatch
//   - All-or-nothing: accepted only when wr_ready_o=1; otherwise no lane is written.
//   - wr_ready_o is computed from the registered count only; no combinational path from any input.
//   - Accepted valid lanes are compacted in lane order into tail, tail+1, ...
//     Gaps in wr_valid_i are allowed; the tail advances by popcount(wr_valid_i).
//   - Lane-0 is older than lane-1.
//   Wake-up
//   - Every cycle, each valid entry sets psrcN_ready when it has psrcN_valid and
//     psrcN == wb_pdest_i[k] with wb_i[k]=1.
//   - Lanes dispatched in the same cycle are also compared against that cycle's wb.
//     A matching source is written with ready=1, so no wake-up is lost.
//   - An unused source (psrcN_valid=0) is treated as ready.
//   Issue
//   - issue_valid_o = head valid & (src0 ready | !src0_valid) & (src1 ready | !src1_valid).
//   - Only the head is ever considered; no younger entry bypasses it.
//   - Pop on issue_valid_o & issue_ready_i: invalidate head, advance head, payload visible same cycle.
//   - issue_payload_o = head payload combinationally; it is don't-care when issue_valid_o=0.
//   Simultaneous events
//   - Push and pop together: count_next = count + accepted - popped.
//   - The freed head slot becomes available to dispatch only in the next cycle.
//   - When full, dispatch is blocked even if a pop occurs in the same cycle.
//   Flush
//   - flush_i has priority over push, pop and wake-up.
//   - Next cycle: head=tail=0, count=0, all entries invalid.
//   - issue_valid_o is forced 0 during the flush cycle, so no handshake completes.
//   Reset
//   - rst has priority over flush.
//   - After reset: count_o=0, issue_valid_o=0, wr_ready_o=1.
//   - Storage payload need not be reset; valid bits must be.
// CONFIGURATION
//   ORS_WB_BYPASS_EN defined:
//   - Head readiness also ORs in the current-cycle wb_i/wb_pdest_i match.
//   - The head may issue in the same cycle its last operand is written back.
//   - Zero-cycle wake-up; adds a combinational path wb -> issue_valid_o.
//   ORS_WB_BYPASS_EN undefined:
//   - Readiness comes from registered bits only; earliest issue is the cycle after wb.
//   - issue_valid_o depends on state and flush_i only.
// TESTING
//   1. Reset, then dispatch 2 lanes (psrc0=5 not ready, psrc1 unused) and hold issue_ready_i=1.
//      -> issue_valid_o=0, count_o=2.
//      Then wb_i=1 with wb_pdest_i=5 at cycle N -> issue_valid_o=1 at N+1 (N with BYPASS_EN),
//      then 2 issues in order.
//   2. RS_SIZE=6: fill 6 entries (3x2 dispatch) -> wr_ready_o=0.
//      Pop 1 -> wr_ready_o stays 0 (free=1 < 2).
//      Pop 2 -> wr_ready_o=1; dispatch 2 -> tail wraps 0->... correctly, FIFO order kept.
//   3. Head waiting on p7, younger entry fully ready -> no issue until wb p7;
//      younger issues in the cycle after the head.
//   4. Dispatch psrc1=9 (ready=0) in the same cycle as wb p9 -> the entry issues the next cycle
//      with no further wb.
//   5. wr_valid_i=2'b10 -> one entry written at the tail, count +1.
//      Push 2 and pop 1 in the same cycle -> count +1.
//   6. flush_i with 5 entries and issue_ready_i=1 -> issue_valid_o=0 that cycle;
//      next cycle count_o=0, wr_ready_o=1.
//      rst mid-stream -> same state.

Source files
------------

// File: rtl/order_issue_queue.sv
// In-order issue queue: multi-lane dispatch into a circular buffer, writeback wake-up, oldest-first issue.
// Optional macro ORS_WB_BYPASS_EN lets the head use same-cycle writeback matches for readiness.
module order_issue_queue #(
  parameter int RS_SIZE        = 8,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WB_WIDTH       = 4,
  parameter int PREG_W         = 6,
  parameter int PAYLOAD_W      = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [DISPATCH_WIDTH-1:0]           wr_valid_i,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]    wr_psrc0_i,
  input  logic [DISPATCH_WIDTH-1:0]           wr_psrc0_valid_i,
  input  logic [DISPATCH_WIDTH-1:0]           wr_psrc0_ready_i,
  input  logic [DISPATCH_WIDTH*PREG_W-1:0]    wr_psrc1_i,
  input  logic [DISPATCH_WIDTH-1:0]           wr_psrc1_valid_i,
  input  logic [DISPATCH_WIDTH-1:0]           wr_psrc1_ready_i,
  input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] wr_payload_i,
  output logic                                wr_ready_o,
  input  logic [WB_WIDTH-1:0]                 wb_i,
  input  logic [WB_WIDTH*PREG_W-1:0]          wb_pdest_i,
  output logic                                issue_valid_o,
  input  logic                                issue_ready_i,
  output logic [PAYLOAD_W-1:0]                issue_payload_o,
  output logic [$clog2(RS_SIZE):0]            count_o
);

  localparam int PW = $clog2(RS_SIZE);
  localparam int CW = $clog2(RS_SIZE) + 1;

  logic [RS_SIZE-1:0]   valid_q, valid_d;
  logic [RS_SIZE-1:0]   s0_v_q, s0_v_d, s0_rdy_q, s0_rdy_d;
  logic [RS_SIZE-1:0]   s1_v_q, s1_v_d, s1_rdy_q, s1_rdy_d;
  logic [PREG_W-1:0]    s0_tag_q [RS_SIZE];
  logic [PREG_W-1:0]    s0_tag_d [RS_SIZE];
  logic [PREG_W-1:0]    s1_tag_q [RS_SIZE];
  logic [PREG_W-1:0]    s1_tag_d [RS_SIZE];
  logic [PAYLOAD_W-1:0] payload_q [RS_SIZE];
  logic [PAYLOAD_W-1:0] payload_d [RS_SIZE];
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;

  logic head_rdy0, head_rdy1, pop;

  function automatic logic wb_match(input logic [PREG_W-1:0]          tag,
                                    input logic [WB_WIDTH-1:0]        wb,
                                    input logic [WB_WIDTH*PREG_W-1:0] pdest);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_WIDTH; k++) begin
      if (wb[k] && (pdest[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Explicit wrap so non-power-of-two sizes stay inside [0, RS_SIZE).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= RS_SIZE) s = s - RS_SIZE;
    return PW'(s);
  endfunction

  assign wr_ready_o = (count_q <= CW'(RS_SIZE - DISPATCH_WIDTH));
  assign count_o    = count_q;

`ifdef ORS_WB_BYPASS_EN
  assign head_rdy0 = s0_rdy_q[head_q] | ~s0_v_q[head_q] | wb_match(s0_tag_q[head_q], wb_i, wb_pdest_i);
  assign head_rdy1 = s1_rdy_q[head_q] | ~s1_v_q[head_q] | wb_match(s1_tag_q[head_q], wb_i, wb_pdest_i);
`else
  assign head_rdy0 = s0_rdy_q[head_q] | ~s0_v_q[head_q];
  assign head_rdy1 = s1_rdy_q[head_q] | ~s1_v_q[head_q];
`endif

  assign issue_valid_o   = valid_q[head_q] & head_rdy0 & head_rdy1 & ~flush_i;
  assign issue_payload_o = payload_q[head_q];
  assign pop             = issue_valid_o & issue_ready_i;

  always_comb begin
    int n_push;
    logic [PW-1:0] idx;
    n_push    = 0;
    idx       = '0;
    valid_d   = valid_q;
    s0_v_d    = s0_v_q;
    s0_rdy_d  = s0_rdy_q;
    s1_v_d    = s1_v_q;
    s1_rdy_d  = s1_rdy_q;
    s0_tag_d  = s0_tag_q;
    s1_tag_d  = s1_tag_q;
    payload_d = payload_q;
    head_d    = head_q;
    tail_d    = tail_q;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (valid_q[i]) begin
        if (s0_v_q[i] && wb_match(s0_tag_q[i], wb_i, wb_pdest_i)) s0_rdy_d[i] = 1'b1;
        if (s1_v_q[i] && wb_match(s1_tag_q[i], wb_i, wb_pdest_i)) s1_rdy_d[i] = 1'b1;
      end
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_add(head_q, 1);
    end

    // Free slots never alias the head when not full, so push and pop cannot collide.
    if (wr_ready_o) begin
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (wr_valid_i[l]) begin
          idx            = ptr_add(tail_q, n_push);
          valid_d[idx]   = 1'b1;
          s0_tag_d[idx]  = wr_psrc0_i[l*PREG_W +: PREG_W];
          s0_v_d[idx]    = wr_psrc0_valid_i[l];
          s0_rdy_d[idx]  = wr_psrc0_ready_i[l] |
                           wb_match(wr_psrc0_i[l*PREG_W +: PREG_W], wb_i, wb_pdest_i);
          s1_tag_d[idx]  = wr_psrc1_i[l*PREG_W +: PREG_W];
          s1_v_d[idx]    = wr_psrc1_valid_i[l];
          s1_rdy_d[idx]  = wr_psrc1_ready_i[l] |
                           wb_match(wr_psrc1_i[l*PREG_W +: PREG_W], wb_i, wb_pdest_i);
          payload_d[idx] = wr_payload_i[l*PAYLOAD_W +: PAYLOAD_W];
          n_push         = n_push + 1;
        end
      end
    end
    tail_d  = ptr_add(tail_q, n_push);
    count_d = count_q + CW'(n_push) - CW'(pop);

    if (flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents are qualified by valid_q and need no reset.
  always_ff @(posedge clk) begin
    s0_v_q    <= s0_v_d;
    s0_rdy_q  <= s0_rdy_d;
    s1_v_q    <= s1_v_d;
    s1_rdy_q  <= s1_rdy_d;
    s0_tag_q  <= s0_tag_d;
    s1_tag_q  <= s1_tag_d;
    payload_q <= payload_d;
  end

endmodule

// File: tb/tb_order_issue_queue.sv
// Directed bench for order_issue_queue with RS_SIZE=6 (exercises non-power-of-two wrap).
// Expectations follow ORS_WB_BYPASS_EN when the macro is defined.
module tb_order_issue_queue;
  localparam int RS  = 6;
  localparam int DW  = 2;
  localparam int WB  = 4;
  localparam int PRW = 6;
  localparam int PLW = 64;
  localparam int CW  = $clog2(RS) + 1;

  logic              clk = 1'b0;
  logic              rst, flush_i;
  logic [DW-1:0]     wr_valid_i, wr_psrc0_valid_i, wr_psrc0_ready_i, wr_psrc1_valid_i, wr_psrc1_ready_i;
  logic [DW*PRW-1:0] wr_psrc0_i, wr_psrc1_i;
  logic [DW*PLW-1:0] wr_payload_i;
  logic              wr_ready_o;
  logic [WB-1:0]     wb_i;
  logic [WB*PRW-1:0] wb_pdest_i;
  logic              issue_valid_o, issue_ready_i;
  logic [PLW-1:0]    issue_payload_o;
  logic [CW-1:0]     count_o;

  int n_checks = 0;
  int n_errors = 0;

  order_issue_queue #(.RS_SIZE(RS), .DISPATCH_WIDTH(DW), .WB_WIDTH(WB),
                      .PREG_W(PRW), .PAYLOAD_W(PLW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_psrc0_i(wr_psrc0_i), .wr_psrc0_valid_i(wr_psrc0_valid_i),
    .wr_psrc0_ready_i(wr_psrc0_ready_i), .wr_psrc1_i(wr_psrc1_i), .wr_psrc1_valid_i(wr_psrc1_valid_i),
    .wr_psrc1_ready_i(wr_psrc1_ready_i), .wr_payload_i(wr_payload_i), .wr_ready_o(wr_ready_o),
    .wb_i(wb_i), .wb_pdest_i(wb_pdest_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_payload_o(issue_payload_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid_i = '0; wr_psrc0_i = '0; wr_psrc0_valid_i = '0; wr_psrc0_ready_i = '0;
    wr_psrc1_i = '0; wr_psrc1_valid_i = '0; wr_psrc1_ready_i = '0; wr_payload_i = '0;
    wb_i = '0; wb_pdest_i = '0; flush_i = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic [PRW-1:0] s0, input logic s0v, input logic s0r,
                          input logic [PRW-1:0] s1, input logic s1v, input logic s1r,
                          input logic [PLW-1:0] pl);
    wr_valid_i[l]                = 1'b1;
    wr_psrc0_i[l*PRW +: PRW]     = s0;
    wr_psrc0_valid_i[l]          = s0v;
    wr_psrc0_ready_i[l]          = s0r;
    wr_psrc1_i[l*PRW +: PRW]     = s1;
    wr_psrc1_valid_i[l]          = s1v;
    wr_psrc1_ready_i[l]          = s1r;
    wr_payload_i[l*PLW +: PLW]   = pl;
  endtask

  // A lane whose sources are both unused, i.e. ready for issue.
  task automatic set_ready_lane(input int l, input logic [PLW-1:0] pl);
    set_lane(l, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, pl);
  endtask

  task automatic set_wb(input int k, input logic [PRW-1:0] tag);
    wb_i[k]                  = 1'b1;
    wb_pdest_i[k*PRW +: PRW] = tag;
  endtask

  task automatic expect_issue(input string tag, input logic [PLW-1:0] pl);
    check({tag, "_valid"}, 64'(issue_valid_o), 64'd1);
    check({tag, "_payload"}, issue_payload_o, pl);
  endtask

  initial begin
    idle_inputs();
    issue_ready_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    check("rst_wr_ready", 64'(wr_ready_o), 64'd1);

    // 1: two entries waiting on p5, then one writeback wakes both
    issue_ready_i = 1'b1;
    set_lane(0, 6'd5, 1'b1, 1'b0, '0, 1'b0, 1'b0, 64'hA1);
    set_lane(1, 6'd5, 1'b1, 1'b0, '0, 1'b0, 1'b0, 64'hA2);
    tick();
    idle_inputs();
    #1;
    check("t1_wait_valid", 64'(issue_valid_o), 64'd0);
    check("t1_count", 64'(count_o), 64'd2);
    set_wb(0, 6'd5);
    #1;
`ifdef ORS_WB_BYPASS_EN
    expect_issue("t1_wb_cycle", 64'hA1);
    tick();
    idle_inputs();
    #1;
`else
    check("t1_wb_cycle_valid", 64'(issue_valid_o), 64'd0);
    tick();
    idle_inputs();
    #1;
    expect_issue("t1_first", 64'hA1);
    check("t1_count_before_pop", 64'(count_o), 64'd2);
    tick();
`endif
    expect_issue("t1_second", 64'hA2);
    tick();
    check("t1_drained_valid", 64'(issue_valid_o), 64'd0);
    check("t1_drained_count", 64'(count_o), 64'd0);

    // 2: fill all six slots, blocked dispatch while full, wrap, FIFO order
    issue_ready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      set_ready_lane(0, 64'hB1 + 64'(2*b));
      set_ready_lane(1, 64'hB2 + 64'(2*b));
      tick();
    end
    idle_inputs();
    #1;
    check("t2_full_count", 64'(count_o), 64'd6);
    check("t2_full_wr_ready", 64'(wr_ready_o), 64'd0);
    expect_issue("t2_head", 64'hB1);
    issue_ready_i = 1'b1;
    set_ready_lane(0, 64'hEE);
    set_ready_lane(1, 64'hEF);
    tick();
    idle_inputs();
    #1;
    check("t2_pop1_count", 64'(count_o), 64'd5);
    check("t2_pop1_wr_ready", 64'(wr_ready_o), 64'd0);
    tick();
    check("t2_pop2_count", 64'(count_o), 64'd4);
    check("t2_pop2_wr_ready", 64'(wr_ready_o), 64'd1);
    issue_ready_i = 1'b0;
    set_ready_lane(0, 64'hB7);
    set_ready_lane(1, 64'hB8);
    tick();
    idle_inputs();
    #1;
    check("t2_refill_count", 64'(count_o), 64'd6);
    issue_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_issue("t2_drain", 64'hB3 + 64'(i));
      tick();
    end
    check("t2_empty_count", 64'(count_o), 64'd0);

    // 3: head blocked on p7 holds back a ready younger entry
    set_lane(0, 6'd7, 1'b1, 1'b0, '0, 1'b0, 1'b0, 64'hC1);
    set_ready_lane(1, 64'hC2);
    tick();
    idle_inputs();
    #1;
    check("t3_blocked_a", 64'(issue_valid_o), 64'd0);
    tick();
    check("t3_blocked_b", 64'(issue_valid_o), 64'd0);
    check("t3_blocked_count", 64'(count_o), 64'd2);
    set_wb(2, 6'd7);
    #1;
`ifdef ORS_WB_BYPASS_EN
    expect_issue("t3_wb_cycle", 64'hC1);
    tick();
    idle_inputs();
    #1;
`else
    check("t3_wb_cycle_valid", 64'(issue_valid_o), 64'd0);
    tick();
    idle_inputs();
    #1;
    expect_issue("t3_head", 64'hC1);
    tick();
`endif
    expect_issue("t3_younger", 64'hC2);
    tick();
    check("t3_done", 64'(issue_valid_o), 64'd0);

    // 4: writeback in the dispatch cycle is captured by the new entry
    set_lane(0, '0, 1'b0, 1'b0, 6'd9, 1'b1, 1'b0, 64'hD1);
    set_wb(3, 6'd9);
    tick();
    idle_inputs();
    #1;
    expect_issue("t4_same_cycle_wb", 64'hD1);
    tick();
    check("t4_done", 64'(issue_valid_o), 64'd0);

    // 5: gap in lane valids, then simultaneous push 2 / pop 1
    issue_ready_i = 1'b0;
    set_ready_lane(0, 64'hEE);
    wr_valid_i = 2'b10;
    set_ready_lane(1, 64'hE1);
    wr_valid_i = 2'b10;
    tick();
    idle_inputs();
    #1;
    check("t5_gap_count", 64'(count_o), 64'd1);
    expect_issue("t5_gap_head", 64'hE1);
    issue_ready_i = 1'b1;
    set_ready_lane(0, 64'hE2);
    set_ready_lane(1, 64'hE3);
    tick();
    idle_inputs();
    #1;
    check("t5_pushpop_count", 64'(count_o), 64'd2);
    expect_issue("t5_next", 64'hE2);
    tick();
    expect_issue("t5_last", 64'hE3);
    tick();
    check("t5_empty", 64'(count_o), 64'd0);

    // 6: flush with 5 entries (push attempted too), then reset mid-stream
    issue_ready_i = 1'b0;
    set_ready_lane(0, 64'hF1); set_ready_lane(1, 64'hF2); tick();
    set_ready_lane(0, 64'hF3); set_ready_lane(1, 64'hF4); tick();
    idle_inputs();
    set_ready_lane(0, 64'hF5); tick();
    idle_inputs();
    #1;
    check("t6_pre_count", 64'(count_o), 64'd5);
    issue_ready_i = 1'b1;
    flush_i = 1'b1;
    set_ready_lane(0, 64'hF6);
    #1;
    check("t6_flush_cycle_valid", 64'(issue_valid_o), 64'd0);
    tick();
    idle_inputs();
    #1;
    check("t6_flush_count", 64'(count_o), 64'd0);
    check("t6_flush_wr_ready", 64'(wr_ready_o), 64'd1);
    check("t6_flush_valid", 64'(issue_valid_o), 64'd0);
    set_ready_lane(0, 64'hF7);
    tick();
    idle_inputs();
    #1;
    expect_issue("t6_after_flush", 64'hF7);
    tick();
    issue_ready_i = 1'b0;
    set_ready_lane(0, 64'h91); set_ready_lane(1, 64'h92); tick();
    idle_inputs();
    rst = 1'b1;
    set_ready_lane(0, 64'h93);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("t6_rst_count", 64'(count_o), 64'd0);
    check("t6_rst_wr_ready", 64'(wr_ready_o), 64'd1);
    check("t6_rst_valid", 64'(issue_valid_o), 64'd0);
    issue_ready_i = 1'b1;
    set_ready_lane(0, 64'h61);
    tick();
    idle_inputs();
    #1;
    expect_issue("t6_after_rst", 64'h61);
    tick();
    check("t6_final_count", 64'(count_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
